blk_e1734f: RTL
===============

// Module: de2_115_sopc_avalon_st_adapter_data_format_adapter_0
// PURPOSE
//   Downstream stage of the timing-adapter FIFO in the DE2-115 SOPC Avalon-ST adapter.
//   Consumes the FIFO's packed 42-bit beats, each carrying 4x8-bit symbols plus packet sideband.
//   Serialises each beat into 1-symbol beats for the 8-bit MAC-side sink.
//   Honours empty on end-of-packet and keeps full backpressure; readyLatency 0 on both sides.
// PARAMETERS
//   SYMBOLS_PER_BEAT  4   input symbols per beat, power of 2
//   BITS_PER_SYMBOL   8   bits per symbol and output data width
//   EMPTY_WIDTH       2   log2(SYMBOLS_PER_BEAT)
//   ERROR_WIDTH       6   error sideband width
//   IN_WIDTH          42  ERROR_WIDTH+2+EMPTY_WIDTH+SYMBOLS_PER_BEAT*BITS_PER_SYMBOL
// PORTS
//   clk                input   1    single clock
//   reset_n            input   1    asynchronous reset, active-low
//   in_valid           input   1    packed beat valid (from FIFO out_valid)
//   in_data            input   42   {error[41:36], sop[35], eop[34], empty[33:32], data[31:0]}
//   in_ready           output  1    beat accepted when in_valid && in_ready
//   out_valid          output  1    symbol valid
//   out_data           output  8    current symbol
//   out_startofpacket  output  1    first symbol of packet
//   out_endofpacket    output  1    last valid symbol of packet
//   out_error          output  6    error sideband (see CONFIGURATION)
//   out_ready          input   1    sink ready; transfer on out_valid && out_ready
// BEHAVIOUR
//   Reset (async, reset_n=0): all registers cleared; in_ready=0 while in reset, 1 in the first cycle after; out_valid=0, out_data=0, sop/eop=0, out_error=0, sym_idx=0, state IDLE.
//   Holding register captures one whole input beat; states IDLE (empty) and EMIT (holding).
//   Symbol order is big-endian: sym_idx=0 selects data[31:24], sym_idx=3 selects data[7:0].
//   last_idx = hold_eop ? (SYMBOLS_PER_BEAT-1-hold_empty) : SYMBOLS_PER_BEAT-1.
//   empty is ignored (treated as 0) when eop=0.
//   in_ready = (state==IDLE) || (out_ready && sym_idx==last_idx): combinational, allows back-to-back beats with no bubble.
//   IDLE->EMIT on accept. The first symbol appears the cycle after accept (latency 1).
//   EMIT: when out_ready, sym_idx increments. At sym_idx==last_idx, the next step depends on the input:
//     - new beat accepted: load it and set sym_idx=0;
//     - no new beat: go to IDLE.
//   out_valid=1 in EMIT. out_startofpacket = hold_sop && sym_idx==0.
//   out_endofpacket = hold_eop && sym_idx==last_idx.
//   out_valid=0: no sideband outputs are meaningful and counters hold.
//   Throughput: 1 symbol/cycle sustained. A full beat needs 4 cycles; an eop beat with empty=e needs 4-e cycles.
//   sop and eop in the same beat with empty=3: one symbol with both flags set.
//   out_ready low: all outputs hold stable (Avalon-ST rule); no input accepted unless IDLE.
//   Reset mid-packet: the partial packet is discarded, with no eop emitted.
//   sym_idx is EMPTY_WIDTH bits wide; wrap is never relied on because it is reloaded at last_idx.
// CONFIGURATION
//   `DE2_115_SOPC_DFA_ERROR_EN defined:
//     - out_error = hold_error on every symbol of the beat;
//     - error bits are OR-accumulated across the packet and presented on the eop symbol;
//     - the accumulator clears after eop.
//   Not defined: error field dropped; out_error tied to 0; no accumulator registers.
// STRUCTURE
//   Package de2_115_sopc_avalon_st_pkg holds:
//     - field offset constants (DATA_LSB, EMPTY_LSB, EOP_BIT, SOP_BIT, ERR_LSB);
//     - typedef dfa_state_t {IDLE, EMIT};
//     - a packed struct for the 42-bit beat.
//   One sub-module: de2_115_sopc_avalon_st_symbol_mux (hold data + sym_idx -> out_data, purely combinational).
// TESTING
//   Reset release, in_valid=0 -> out_valid=0 and in_ready=1 indefinitely.
//   Single beat: data=0x11223344, sop=1, eop=1, empty=0, out_ready=1 ->
//     out_data 11,22,33,44 on 4 consecutive cycles; sop on 0x11, eop on 0x44.
//   Two-beat packet, continuous in_valid: data 0xA0A1A2A3, then 0xB0B1B2B3 with eop and empty=2 ->
//     6 symbols A0..A3,B0,B1 with no bubble; in_ready high on cycles 4 and 6 only; eop on B1.
//   Backpressure: toggle out_ready every cycle on the above -> same symbol sequence, outputs stable while stalled.
//   Reset asserted after 2 symbols, new packet sent afterwards -> no stale symbols; new packet starts with sop.
//   With the macro: error=6'h04 on beat 1 and 6'h01 on the eop beat -> out_error=6'h05 on the eop symbol. Without it: 0.

Source files
------------

// File: rtl/de2_115_sopc_avalon_st_pkg.sv
// rtl/de2_115_sopc_avalon_st_pkg.sv - shared types and constants for the Avalon-ST data format adapter
// Purpose : beat geometry, packed-beat field offsets, adapter FSM state type and
//           the last-symbol index helper used by blk_e1734f.
// Ports   : none (package).
package de2_115_sopc_avalon_st_pkg;

   localparam int SYMBOLS_PER_BEAT = 4;
   localparam int BITS_PER_SYMBOL  = 8;
   localparam int EMPTY_WIDTH      = 2;
   localparam int ERROR_WIDTH      = 6;
   localparam int DATA_WIDTH       = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
   localparam int IN_WIDTH         = ERROR_WIDTH + 2 + EMPTY_WIDTH + DATA_WIDTH;

   // Field offsets inside the packed 42-bit beat
   localparam int DATA_LSB  = 0;
   localparam int EMPTY_LSB = DATA_WIDTH;
   localparam int EOP_BIT   = EMPTY_LSB + EMPTY_WIDTH;
   localparam int SOP_BIT   = EOP_BIT + 1;
   localparam int ERR_LSB   = SOP_BIT + 1;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } dfa_state_t;

   typedef struct packed {
      logic [ERROR_WIDTH-1:0] error;
      logic                   sop;
      logic                   eop;
      logic [EMPTY_WIDTH-1:0] empty;
      logic [DATA_WIDTH-1:0]  data;
   } dfa_beat_t;

   // Index of the final valid symbol; empty only counts on an end-of-packet beat.
   function automatic logic [EMPTY_WIDTH-1:0] last_index(input logic eop,
                                                         input logic [EMPTY_WIDTH-1:0] empty);
      logic [EMPTY_WIDTH-1:0] full_last;
      full_last = EMPTY_WIDTH'(SYMBOLS_PER_BEAT - 1);
      return eop ? (full_last - empty) : full_last;
   endfunction

endpackage

// File: rtl/de2_115_sopc_avalon_st_symbol_mux.sv
// rtl/de2_115_sopc_avalon_st_symbol_mux.sv - big-endian symbol selector for the held beat
// Purpose : purely combinational; picks one symbol out of the held data word.
//           sym_idx=0 selects the most significant symbol.
// Ports   : data    in  held beat data
//           sym_idx in  symbol index
//           symbol  out selected symbol
module de2_115_sopc_avalon_st_symbol_mux
   import de2_115_sopc_avalon_st_pkg::*;
(
   input  logic [DATA_WIDTH-1:0]      data,
   input  logic [EMPTY_WIDTH-1:0]     sym_idx,
   output logic [BITS_PER_SYMBOL-1:0] symbol
);

   always_comb begin
      symbol = '0;
      for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
         if (sym_idx == EMPTY_WIDTH'(SYMBOLS_PER_BEAT - 1 - i)) begin
            symbol = data[i*BITS_PER_SYMBOL +: BITS_PER_SYMBOL];
         end
      end
   end

endmodule

// File: rtl/blk_e1734f.sv
// rtl/blk_e1734f.sv - Avalon-ST data format adapter, 4-symbol beats to 1-symbol beats
// Purpose : captures one packed beat from the timing-adapter FIFO and serialises it
//           symbol by symbol to an 8-bit sink, honouring empty on end-of-packet and
//           full backpressure (readyLatency 0 on both sides).
// Config  : define DE2_115_SOPC_DFA_ERROR_EN to carry the error sideband; otherwise
//           out_error is tied to 0 and no accumulator exists.
// Ports   : clk, reset_n (async, active-low)
//           in_valid/in_data/in_ready        packed beat input {error,sop,eop,empty,data}
//           out_valid/out_data/out_ready     symbol output
//           out_startofpacket/out_endofpacket/out_error  per-symbol sideband
module blk_e1734f
   import de2_115_sopc_avalon_st_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic [IN_WIDTH-1:0]        in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [BITS_PER_SYMBOL-1:0] out_data,
   output logic                       out_startofpacket,
   output logic                       out_endofpacket,
   output logic [ERROR_WIDTH-1:0]     out_error,
   input  logic                       out_ready
);

   dfa_state_t             state_q, state_d;
   dfa_beat_t              beat_in;
   logic [DATA_WIDTH-1:0]  hold_data_q;
   logic                   hold_sop_q, hold_eop_q;
   logic [EMPTY_WIDTH-1:0] hold_empty_q;
   logic [EMPTY_WIDTH-1:0] sym_idx_q, sym_idx_d;
   logic [EMPTY_WIDTH-1:0] last_idx;
   logic                   ready_en_q;
   logic                   at_last;
   logic                   accept;
   logic                   load;
   logic [BITS_PER_SYMBOL-1:0] mux_symbol;

   assign beat_in  = dfa_beat_t'(in_data);
   assign last_idx = last_index(hold_eop_q, hold_empty_q);
   assign at_last  = (sym_idx_q == last_idx);

   // ready_en_q keeps in_ready low while in reset even though the FSM sits in IDLE.
   assign in_ready = ready_en_q && ((state_q == IDLE) || (out_ready && at_last));
   assign accept   = in_valid && in_ready;
   assign load     = accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sym_idx_d = sym_idx_q;
      case (state_q)
         IDLE: begin
            sym_idx_d = '0;
            if (accept) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (at_last) begin
                  sym_idx_d = '0;
                  if (!accept) begin
                     state_d = IDLE;
                  end
               end else begin
                  sym_idx_d = sym_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            sym_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_en_q   <= 1'b0;
         sym_idx_q    <= '0;
         hold_data_q  <= '0;
         hold_sop_q   <= 1'b0;
         hold_eop_q   <= 1'b0;
         hold_empty_q <= '0;
      end else begin
         ready_en_q <= 1'b1;
         sym_idx_q  <= sym_idx_d;
         if (load) begin
            hold_data_q  <= beat_in.data;
            hold_sop_q   <= beat_in.sop;
            hold_eop_q   <= beat_in.eop;
            // empty has no meaning without eop; store 0 so last_idx stays full-width
            hold_empty_q <= beat_in.eop ? beat_in.empty : '0;
         end
      end
   end

   de2_115_sopc_avalon_st_symbol_mux u_symbol_mux (
      .data    (hold_data_q),
      .sym_idx (sym_idx_q),
      .symbol  (mux_symbol)
   );

   assign out_valid         = (state_q == EMIT);
   assign out_data          = out_valid ? mux_symbol : '0;
   assign out_startofpacket = out_valid && hold_sop_q && (sym_idx_q == '0);
   assign out_endofpacket   = out_valid && hold_eop_q && at_last;

`ifdef DE2_115_SOPC_DFA_ERROR_EN
   logic [ERROR_WIDTH-1:0] hold_error_q;
   logic [ERROR_WIDTH-1:0] err_acc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_error_q <= '0;
         err_acc_q    <= '0;
      end else begin
         if (load) begin
            hold_error_q <= beat_in.error;
         end
         // Fold each completed beat into the packet accumulator; clear once eop leaves.
         if (out_valid && out_ready && at_last) begin
            err_acc_q <= hold_eop_q ? '0 : (err_acc_q | hold_error_q);
         end
      end
   end

   assign out_error = !out_valid      ? '0 :
                      out_endofpacket ? (err_acc_q | hold_error_q) :
                                        hold_error_q;
`else
   logic err_field_unused;
   assign err_field_unused = ^beat_in.error;
   assign out_error        = '0;
`endif

endmodule
